// File: rtl/speed_pkg.sv
// Rate table and half-period helper shared by speed_tick_gen and its counter.
package speed_pkg;

   localparam int unsigned MAX_SPEEDS = 4;
   localparam int unsigned RATE_HZ [MAX_SPEEDS] = '{2, 5, 10, 20};

   typedef logic [$clog2(MAX_SPEEDS)-1:0] speed_idx_t;

   // Truncated clk_hz/(2*rate); never below one cycle so a too-fast rate still toggles.
   function automatic int unsigned half_period(input int unsigned clk_hz, input int unsigned idx);
      int unsigned h;
      if (idx >= MAX_SPEEDS) begin
         h = 1;
      end else begin
         h = clk_hz / (2 * RATE_HZ[speed_idx_t'(idx)]);
      end
      if (h < 1) begin
         h = 1;
      end
      return h;
   endfunction

endpackage

// File: rtl/half_period_cnt.sv
// Half-period counter: counts while enabled, flags the last cycle of a half-period
// and wraps to zero; load_zero_i forces a restart on the next edge.
module half_period_cnt #(
   parameter int unsigned CNT_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             load_zero_i,
   input  logic [CNT_W-1:0] half_i,
   output logic             wrap_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign wrap_o = en_i && (cnt_q == (half_i - 1'b1));

   always_comb begin
      cnt_d = cnt_q;
      if (load_zero_i || wrap_o) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/speed_tick_gen.sv
// Selectable-rate square wave plus clock-enable tick, switching speed only at a wrap.
// Build option SPEED_BTN_EN replaces the speed input with btn_up/btn_dn stepping.
module speed_tick_gen #(
   parameter int unsigned CLK_HZ        = 50_000_000,
   parameter int unsigned NUM_SPEEDS    = 4,
   parameter int unsigned SEL_W         = $clog2(NUM_SPEEDS),
   parameter int unsigned CNT_W         = 24,
   parameter int unsigned DEFAULT_SPEED = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [SEL_W-1:0] speed,
`ifdef SPEED_BTN_EN
   input  logic             btn_up,
   input  logic             btn_dn,
`endif
   output logic             clko,
   output logic             tick,
   output logic [SEL_W-1:0] speed_cur,
   output logic             speed_pend
);

   import speed_pkg::*;

   logic [CNT_W-1:0] half_tbl [NUM_SPEEDS];

   generate
      for (genvar gi = 0; gi < NUM_SPEEDS; gi++) begin : g_half
         localparam int unsigned HP = half_period(CLK_HZ, gi);
         assign half_tbl[gi] = HP[CNT_W-1:0];
      end
   endgenerate

   logic             clko_q, clko_d;
   logic             tick_q, tick_d;
   logic             pend_q, pend_d;
   logic [SEL_W-1:0] speed_cur_q, speed_cur_d;
   logic [SEL_W-1:0] target_q, target_d;
   logic             wrap;
   logic             switch_now;
   logic             req_hit;
   logic [SEL_W-1:0] req_idx;

   // req_hit: a usable request is present this cycle; req_idx is what it asks for.
`ifdef SPEED_BTN_EN
   localparam logic [SEL_W-1:0] TOP_IDX = SEL_W'(NUM_SPEEDS - 1);

   always_comb begin
      req_hit = btn_up ^ btn_dn;
      req_idx = speed_cur_q;
      if (btn_up && !btn_dn) begin
         req_idx = (speed_cur_q == TOP_IDX) ? speed_cur_q : speed_cur_q + 1'b1;
      end else if (btn_dn && !btn_up) begin
         req_idx = (speed_cur_q == '0) ? speed_cur_q : speed_cur_q - 1'b1;
      end
   end
`else
   localparam logic [SEL_W:0] NUM_S = (SEL_W + 1)'(NUM_SPEEDS);

   always_comb begin
      req_hit = ({1'b0, speed} < NUM_S);
      req_idx = speed;
   end
`endif

   half_period_cnt #(
      .CNT_W(CNT_W)
   ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .en_i       (en),
      .load_zero_i(switch_now),
      .half_i     (half_tbl[speed_cur_q]),
      .wrap_o     (wrap)
   );

   // A request equal to speed_cur cancels; an absent request at a wrap commits the target.
   always_comb begin
      speed_cur_d = speed_cur_q;
      target_d    = target_q;
      pend_d      = pend_q;
      clko_d      = clko_q;
      tick_d      = 1'b0;
      switch_now  = 1'b0;
      if (wrap) begin
         clko_d = ~clko_q;
         tick_d = ~clko_q;
         pend_d = 1'b0;
         if (req_hit && (req_idx != speed_cur_q)) begin
            speed_cur_d = req_idx;
            switch_now  = 1'b1;
         end else if (!req_hit && pend_q) begin
            speed_cur_d = target_q;
            switch_now  = 1'b1;
         end
      end else if (req_hit) begin
         pend_d   = (req_idx != speed_cur_q);
         target_d = req_idx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clko_q      <= 1'b0;
         tick_q      <= 1'b0;
         pend_q      <= 1'b0;
         speed_cur_q <= SEL_W'(DEFAULT_SPEED);
         target_q    <= SEL_W'(DEFAULT_SPEED);
      end else begin
         clko_q      <= clko_d;
         tick_q      <= tick_d;
         pend_q      <= pend_d;
         speed_cur_q <= speed_cur_d;
         target_q    <= target_d;
      end
   end

   assign clko       = clko_q;
   assign tick       = tick_q;
   assign speed_cur  = speed_cur_q;
   assign speed_pend = pend_q;

endmodule

// File: tb/tb_speed_tick_gen.sv
// Directed bench for speed_tick_gen at CLK_HZ=100 (HALF = 25, 10, 5, 2).
module tb_speed_tick_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [1:0] speed = 2'd0;
   logic       clko, tick, pend;
   logic [1:0] cur;
   logic       clko3, tick3, pend3;
   logic [1:0] cur3;
`ifdef SPEED_BTN_EN
   logic       btn_up = 1'b0;
   logic       btn_dn = 1'b0;
`endif

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   speed_tick_gen #(.CLK_HZ(100), .NUM_SPEEDS(4), .CNT_W(24), .DEFAULT_SPEED(0)) dut (
      .clk(clk), .rst(rst), .en(en), .speed(speed),
`ifdef SPEED_BTN_EN
      .btn_up(btn_up), .btn_dn(btn_dn),
`endif
      .clko(clko), .tick(tick), .speed_cur(cur), .speed_pend(pend)
   );

   speed_tick_gen #(.CLK_HZ(100), .NUM_SPEEDS(3), .CNT_W(24), .DEFAULT_SPEED(0)) dut3 (
      .clk(clk), .rst(rst), .en(en), .speed(speed),
`ifdef SPEED_BTN_EN
      .btn_up(btn_up), .btn_dn(btn_dn),
`endif
      .clko(clko3), .tick(tick3), .speed_cur(cur3), .speed_pend(pend3)
   );

   typedef struct {
      int         n;
      logic       en;
      logic [1:0] spd;
      logic       clko;
      logic       tick;
      logic [1:0] cur;
      logic       pend;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset(input logic [1:0] spd, input logic e);
      @(posedge clk);
      #1;
      rst   = 1'b1;
      speed = spd;
      en    = e;
      step(2);
      rst = 1'b0;
   endtask

   task automatic wait_tick(output int cyc);
      cyc = 0;
      do begin
         step(1);
         cyc++;
      end while (!tick && cyc < 200);
   endtask

   task automatic measure_run(output int len);
      logic v;
      v   = clko;
      len = 0;
      do begin
         step(1);
         len++;
      end while (clko == v && len < 100);
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      int cyc;
      int run;
      logic frozen_ok;

      // Cumulative edges after reset release: 1,24,25,26,29,30,34,35,44,45.
      vecs[0] = '{1,  1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 1'b1};
      vecs[1] = '{23, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 1'b1};
      vecs[2] = '{1,  1'b1, 2'd2, 1'b1, 1'b1, 2'd2, 1'b0};
      vecs[3] = '{1,  1'b1, 2'd2, 1'b1, 1'b0, 2'd2, 1'b0};
      vecs[4] = '{3,  1'b1, 2'd2, 1'b1, 1'b0, 2'd2, 1'b0};
      vecs[5] = '{1,  1'b1, 2'd2, 1'b0, 1'b0, 2'd2, 1'b0};
      vecs[6] = '{4,  1'b1, 2'd2, 1'b0, 1'b0, 2'd2, 1'b0};
      vecs[7] = '{1,  1'b1, 2'd2, 1'b1, 1'b1, 2'd2, 1'b0};
      vecs[8] = '{9,  1'b1, 2'd2, 1'b0, 1'b0, 2'd2, 1'b0};
      vecs[9] = '{1,  1'b1, 2'd2, 1'b1, 1'b1, 2'd2, 1'b0};

      step(3);
      chk("reset clko", int'(clko), 0);
      chk("reset tick", int'(tick), 0);
      chk("reset cur", int'(cur), 0);
      chk("reset pend", int'(pend), 0);

      // Speed 2 from reset: switch lands on the first speed-0 wrap.
      do_reset(2'd2, 1'b1);
      for (int i = 0; i < 10; i++) begin
         en    = vecs[i].en;
         speed = vecs[i].spd;
         step(vecs[i].n);
         $display("row %0d: clko=%0b tick=%0b cur=%0d pend=%0b", i, clko, tick, cur, pend);
         chk($sformatf("row%0d clko", i), int'(clko), int'(vecs[i].clko));
         chk($sformatf("row%0d tick", i), int'(tick), int'(vecs[i].tick));
         chk($sformatf("row%0d cur", i), int'(cur), int'(vecs[i].cur));
         chk($sformatf("row%0d pend", i), int'(pend), int'(vecs[i].pend));
      end

      // Request speed 3 at cnt=3: pending for 21 cycles, then 2-cycle half-periods.
      do_reset(2'd0, 1'b1);
      step(3);
      chk("s2 pend idle", int'(pend), 0);
      speed = 2'd3;
      step(1);
      chk("s2 pend set", int'(pend), 1);
      n = 1;
      while (n < 100) begin
         step(1);
         if (!pend) break;
         n++;
      end
      $display("s2: pend cycles=%0d cur=%0d", n, cur);
      chk("s2 pend len", n, 21);
      chk("s2 cur", int'(cur), 3);
      chk("s2 clko", int'(clko), 1);
      chk("s2 tick", int'(tick), 1);
      for (int k = 0; k < 3; k++) begin
         measure_run(run);
         $display("s2: run %0d len=%0d", k, run);
         chk($sformatf("s2 run%0d", k), run, 2);
      end

      // Request withdrawn before the wrap: pend clears, period stays 50.
      do_reset(2'd0, 1'b1);
      step(2);
      speed = 2'd1;
      step(4);
      chk("s3 pend set", int'(pend), 1);
      speed = 2'd0;
      step(1);
      chk("s3 pend clr", int'(pend), 0);
      wait_tick(cyc);
      chk("s3 first tick", cyc, 18);
      wait_tick(cyc);
      $display("s3: period=%0d cur=%0d", cyc, cur);
      chk("s3 period", cyc, 50);
      chk("s3 cur", int'(cur), 0);

      // Freeze for 7 cycles mid-period: stretches the period by exactly 7.
      step(10);
      en = 1'b0;
      frozen_ok = 1'b1;
      for (int k = 0; k < 7; k++) begin
         step(1);
         if (clko !== 1'b1 || tick !== 1'b0) frozen_ok = 1'b0;
      end
      chk("s4 frozen", int'(frozen_ok), 1);
      en = 1'b1;
      wait_tick(cyc);
      $display("s4: stretched period=%0d", 17 + cyc);
      chk("s4 period", 17 + cyc, 57);

      // New request arriving exactly on a wrap is taken at that wrap.
      do_reset(2'd0, 1'b1);
      step(24);
      speed = 2'd1;
      step(1);
      chk("s6 cur", int'(cur), 1);
      chk("s6 pend", int'(pend), 0);
      chk("s6 tick", int'(tick), 1);
      wait_tick(cyc);
      $display("s6: period after switch=%0d", cyc);
      chk("s6 period", cyc, 20);

      // Out-of-range index on the 3-speed instance; then async reset mid-tick.
      do_reset(2'd3, 1'b1);
      step(1);
      chk("s5 pend3", int'(pend3), 0);
      chk("s5 pend4", int'(pend), 1);
      step(24);
      chk("s5 cur3", int'(cur3), 0);
      chk("s5 pend3 late", int'(pend3), 0);
      chk("s5 clko3", int'(clko3), 1);
      chk("s5 tick4", int'(tick), 1);
      chk("s5 cur4", int'(cur), 3);
      rst = 1'b1;
      #1;
      $display("s5: after async reset clko=%0b tick=%0b", clko, tick);
      chk("s5 rst clko", int'(clko), 0);
      chk("s5 rst tick", int'(tick), 0);
      chk("s5 rst cur", int'(cur), 0);
      chk("s5 rst clko3", int'(clko3), 0);

`ifdef SPEED_BTN_EN
      // Buttons step speed_cur and saturate; speed input is ignored.
      do_reset(2'd2, 1'b1);
      for (int k = 0; k < 5; k++) begin
         btn_up = 1'b1;
         step(1);
         btn_up = 1'b0;
         step(60);
         $display("btn: press %0d cur=%0d", k, cur);
         if (k == 0) chk("btn first", int'(cur), 1);
      end
      chk("btn sat", int'(cur), 3);
      btn_up = 1'b1;
      btn_dn = 1'b1;
      step(1);
      btn_up = 1'b0;
      btn_dn = 1'b0;
      chk("btn both pend", int'(pend), 0);
      step(60);
      chk("btn both cur", int'(cur), 3);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
